tlx_lane_training_monitor: RTL and testbench

Parametrised, multi-lane successor to the single-lane TLX training monitor in the SoC test environment. For each of NUM_LANES serial lanes, it hunts for a fixed training pattern on the forward (FWD) lane and checks alignment. It declares per-lane lock, counts bit errors, and drives the reverse (REV) lane with either loopback or generated pattern once locked. It sits between the SoC TLX pads and the TLX memory model, and runs in the single bench clock domain.

---
 rtl/tlx_lane_training_monitor.sv | 147 ++++++++++++++
 tb/tb_tlx_lane_training_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlx_lane_training_monitor.sv
// Multi-lane TLX training monitor.
// Each lane hunts for TRAIN_PATTERN on its forward serial bit, aligns to it,
// qualifies alignment over LOCK_PERIODS clean pattern periods, and then holds
// lock while it keeps checking. Bit errors after alignment are counted in a
// saturating per-lane counter. Once a lane is locked, its reverse bit either
// echoes the forward bit or regenerates the pattern in phase with it.
module tlx_lane_training_monitor #(
   parameter int                         NUM_LANES     = 4,
   parameter int                         PATTERN_WIDTH = 16,
   parameter logic [PATTERN_WIDTH-1:0]   TRAIN_PATTERN = 16'h5A3C,
   parameter int                         LOCK_PERIODS  = 4,
   parameter int                         ERR_W         = 8,
   parameter int                         REV_MODE      = 0
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [NUM_LANES-1:0]         OE,
   input  logic                         ERR_CLR,
   input  logic [NUM_LANES-1:0]         FWD_DATA_IN,
   input  logic [NUM_LANES-1:0]         REV_DATA_IN,
   output logic [NUM_LANES-1:0]         REV_DATA_OUT,
   output logic [NUM_LANES-1:0]         LOCKED,
   output logic                         ALL_LOCKED,
   output logic [NUM_LANES*ERR_W-1:0]   ERR_CNT
);

   localparam int                   PHASE_W  = (PATTERN_WIDTH > 1) ? $clog2(PATTERN_WIDTH) : 1;
   localparam logic [PHASE_W-1:0]   PH_LAST  = PHASE_W'(PATTERN_WIDTH - 1);
   localparam logic [7:0]           PER_LAST = 8'(LOCK_PERIODS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HUNT  = 2'd1,
      S_CHECK = 2'd2,
      S_LOCK  = 2'd3
   } state_t;

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   logic all_locked_p1;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      state_t                   state_q;
      state_t                   state_d;
      logic [PATTERN_WIDTH-1:0] sr_q;
      logic [PATTERN_WIDTH-1:0] sr_shift;
      logic [PHASE_W-1:0]       phase_q;
      logic [7:0]               per_q;
      logic [ERR_W-1:0]         err_q;
      logic                     rev_p1;
      logic                     lane_locked;
      logic                     hit;
      logic                     mism;
      logic                     wrap;
      logic                     checking;
      logic                     err_evt;

      // Per-lane decode: candidate shift value, pattern hit, bit compare, phase wrap.
      always_comb begin
         sr_shift = {FWD_DATA_IN[i], sr_q[PATTERN_WIDTH-1:1]};
         hit      = (sr_shift == TRAIN_PATTERN);
         mism     = (FWD_DATA_IN[i] != TRAIN_PATTERN[phase_q]);
         wrap     = (phase_q == PH_LAST);
         // Comparison only counts once aligned, and never in the cycle OE drops.
         checking = OE[i] && ((state_q == S_CHECK) || (state_q == S_LOCK));
         err_evt  = checking && mism;
      end

      // Lane state register.
      always_ff @(posedge CLK) begin
         if (RESET) state_q <= S_IDLE;
         else       state_q <= state_d;
      end

      // Lane next-state: OE low forces IDLE from anywhere.
      always_comb begin
         state_d = state_q;
         if (!OE[i]) begin
            state_d = S_IDLE;
         end else begin
            case (state_q)
               S_IDLE:  state_d = S_HUNT;
               S_HUNT:  if (hit) state_d = S_CHECK;
               S_CHECK: begin
                  if (mism)                               state_d = S_HUNT;
                  else if (wrap && (per_q == PER_LAST))   state_d = S_LOCK;
               end
               S_LOCK:  if (mism) state_d = S_HUNT;
               default: state_d = S_IDLE;
            endcase
         end
      end

      // Lane outputs decoded from the registered state only.
      always_comb begin
         lane_locked = (state_q == S_LOCK);
      end

      // Alignment datapath: shift register while hunting, phase/period while checking.
      always_ff @(posedge CLK) begin
         if (RESET) begin
            sr_q    <= '0;
            phase_q <= '0;
            per_q   <= '0;
         end else begin
            sr_q <= (OE[i] && (state_q == S_HUNT)) ? sr_shift : '0;
            if (checking && !mism) begin
               phase_q <= wrap ? '0 : phase_q + PHASE_W'(1);
               per_q   <= (state_q == S_CHECK && wrap) ? per_q + 8'd1 : per_q;
            end else begin
               phase_q <= '0;
               per_q   <= '0;
            end
         end
      end

      // Saturating error counter; a clear beats a simultaneous error.
      always_ff @(posedge CLK) begin
         if (RESET || ERR_CLR) err_q <= '0;
         else if (err_evt)     err_q <= sat_inc(err_q);
      end

      // Reverse lane: pass-through until locked, then echo or regenerate.
      always_ff @(posedge CLK) begin
         if (RESET)                  rev_p1 <= 1'b0;
         else if (state_q == S_LOCK) rev_p1 <= (REV_MODE != 0) ? TRAIN_PATTERN[phase_q]
                                                               : FWD_DATA_IN[i];
         else                        rev_p1 <= REV_DATA_IN[i];
      end

      assign LOCKED[i]                   = lane_locked;
      assign REV_DATA_OUT[i]             = rev_p1;
      assign ERR_CNT[i*ERR_W +: ERR_W]   = err_q;
   end

   // Aggregate lock over enabled lanes, registered one cycle behind LOCKED.
   always_ff @(posedge CLK) begin
      if (RESET) all_locked_p1 <= 1'b0;
      else       all_locked_p1 <= (|OE) && (&(LOCKED | ~OE));
   end

   assign ALL_LOCKED = all_locked_p1;

endmodule

// File: tb/tb_tlx_lane_training_monitor.sv
// Bench for tlx_lane_training_monitor. Two instances share one stimulus:
// dut_a uses the defaults (ERR_W=8, echo mode), dut_b uses ERR_W=4 and
// pattern-regeneration mode. Expected values are queued with the edge that
// produces them; a negedge monitor pops and compares.
module tb_tlx_lane_training_monitor;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  OE;
   logic        ERR_CLR;
   logic [3:0]  FWD;
   logic [3:0]  REVIN;

   logic [3:0]  rev_a, lock_a, rev_b, lock_b;
   logic        all_a, all_b;
   logic [31:0] err_a;
   logic [15:0] err_b;

   always #5 CLK = ~CLK;

   tlx_lane_training_monitor #(
      .NUM_LANES(4), .PATTERN_WIDTH(16), .TRAIN_PATTERN(16'h5A3C),
      .LOCK_PERIODS(4), .ERR_W(8), .REV_MODE(0)
   ) dut_a (
      .CLK(CLK), .RESET(RESET), .OE(OE), .ERR_CLR(ERR_CLR),
      .FWD_DATA_IN(FWD), .REV_DATA_IN(REVIN), .REV_DATA_OUT(rev_a),
      .LOCKED(lock_a), .ALL_LOCKED(all_a), .ERR_CNT(err_a)
   );

   tlx_lane_training_monitor #(
      .NUM_LANES(4), .PATTERN_WIDTH(16), .TRAIN_PATTERN(16'h5A3C),
      .LOCK_PERIODS(4), .ERR_W(4), .REV_MODE(1)
   ) dut_b (
      .CLK(CLK), .RESET(RESET), .OE(OE), .ERR_CLR(ERR_CLR),
      .FWD_DATA_IN(FWD), .REV_DATA_IN(REVIN), .REV_DATA_OUT(rev_b),
      .LOCKED(lock_b), .ALL_LOCKED(all_b), .ERR_CNT(err_b)
   );

   typedef struct {
      int          edge_no;
      int          kind;
      logic [31:0] exp;
   } item_t;

   item_t       sb_q[$];
   int          n_edges  = 0;
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] tp_v     = 16'h5A3C;
   string       kname [0:7] = '{"LOCKED_A", "LOCKED_B", "ALL_LOCKED_A", "ALL_LOCKED_B",
                                "ERR_CNT_A", "ERR_CNT_B", "REV_OUT_A", "REV_OUT_B"};

   always @(posedge CLK) n_edges <= n_edges + 1;

   // Monitor: compare every queued expectation whose edge has occurred.
   always @(negedge CLK) begin
      item_t       it;
      logic [31:0] act;
      while (sb_q.size() > 0 && sb_q[0].edge_no <= n_edges) begin
         it = sb_q.pop_front();
         case (it.kind)
            0:       act = {28'd0, lock_a};
            1:       act = {28'd0, lock_b};
            2:       act = {31'd0, all_a};
            3:       act = {31'd0, all_b};
            4:       act = err_a;
            5:       act = {16'd0, err_b};
            6:       act = {28'd0, rev_a};
            default: act = {28'd0, rev_b};
         endcase
         n_checks = n_checks + 1;
         if (act !== it.exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at edge %0d: got %h, expected %h",
                     kname[it.kind], it.edge_no, act, it.exp);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- hand-derived schedule (idx = pattern bit index) ----------------
   function automatic logic [3:0] exp_lock(input int idx);
      logic [3:0] r;
      if (idx < 0) return 4'd0;
      r[0] = (idx >= 79 && idx <= 939) || (idx >= 1023 && idx <= 1024) || (idx >= 1151);
      r[1] = (idx >= 79 && idx <= 259) || (idx >= 1023 && idx <= 1027) || (idx >= 1151);
      r[2] = (idx >= 79 && idx <= 164) || (idx >= 255 && idx <= 1027) || (idx >= 1151);
      r[3] = (idx >= 79 && idx <= 1027) || (idx >= 1151);
      return r;
   endfunction

   function automatic logic [3:0] oe_of(input int idx);
      logic [3:0] r;
      r = 4'hF;
      if (idx >= 940 && idx <= 942)  r[0] = 1'b0;
      if (idx >= 1025 && idx <= 1027) r[0] = 1'b0;
      if (idx >= 1028 && idx <= 1031) r = 4'h0;
      return r;
   endfunction

   function automatic logic [3:0] flip_of(input int idx);
      logic [3:0] r;
      r = 4'h0;
      if (idx == 165) r[2] = 1'b1;
      if (idx >= 260 && idx <= 932 && ((idx - 260) % 32) == 0) r[1] = 1'b1;
      if (idx == 940) r[0] = 1'b1;
      return r;
   endfunction

   function automatic int err1_of(input int idx);
      if (idx >= 1070) return 0;
      if (idx >= 932)  return 1;
      if (idx >= 900)  return 0;
      if (idx >= 260)  return (idx - 260) / 32 + 1;
      return 0;
   endfunction

   function automatic int err2_of(input int idx);
      return (idx >= 165 && idx < 900) ? 1 : 0;
   endfunction

   function automatic logic [3:0] rv_of(input int idx);
      logic [31:0] t;
      t = (idx * 5 + 3) ^ (idx >> 3);
      return t[3:0];
   endfunction

   task automatic push(input int kind, input logic [31:0] exp);
      item_t it;
      it.edge_no = n_edges + 1;
      it.kind    = kind;
      it.exp     = exp;
      sb_q.push_back(it);
   endtask

   task automatic push_all(input logic [3:0] lk, input logic al, input logic [31:0] ea,
                           input logic [15:0] eb, input logic [3:0] ra, input logic [3:0] rb);
      push(0, {28'd0, lk});
      push(1, {28'd0, lk});
      push(2, {31'd0, al});
      push(3, {31'd0, al});
      push(4, ea);
      push(5, {16'd0, eb});
      push(6, {28'd0, ra});
      push(7, {28'd0, rb});
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [4:0]  prefix;
      logic [3:0]  lk, pre, oe, fl, ra, rb;
      logic        al, tb_bit;
      int          e1, e2;
      logic [7:0]  e1a, e2a;
      logic [3:0]  e1b, e2b;

      prefix  = 5'b11011;
      RESET   = 1'b1;
      OE      = 4'h0;
      ERR_CLR = 1'b0;
      FWD     = 4'h0;
      REVIN   = 4'h0;

      // Reset: everything reads zero.
      for (int k = 0; k < 2; k++) begin
         REVIN = 4'hA;
         push_all(4'h0, 1'b0, 32'd0, 16'd0, 4'h0, 4'h0);
         tick();
      end

      // IDLE->HUNT edge, then five non-pattern bits; reverse lane passes through.
      RESET = 1'b0;
      OE    = 4'hF;
      for (int k = 0; k < 6; k++) begin
         FWD   = (k == 0) ? 4'h0 : {4{prefix[k-1]}};
         REVIN = rv_of(2000 + k);
         push_all(4'h0, 1'b0, 32'd0, 16'd0, REVIN, REVIN);
         tick();
      end

      // Pattern stream with lock, error, saturation, OE-drop and reset events.
      for (int idx = 0; idx <= 1160; idx++) begin
         oe      = oe_of(idx);
         fl      = flip_of(idx);
         tb_bit  = tp_v[idx % 16];
         RESET   = (idx == 1070);
         ERR_CLR = (idx == 900);
         OE      = oe;
         FWD     = {4{tb_bit}} ^ fl;
         REVIN   = rv_of(idx);

         lk  = exp_lock(idx);
         pre = exp_lock(idx - 1);
         al  = (idx != 1070) && (oe != 4'h0) && ((pre | ~oe) == 4'hF);

         e1  = err1_of(idx);
         e2  = err2_of(idx);
         e1a = (e1 > 255) ? 8'd255 : 8'(e1);
         e2a = 8'(e2);
         e1b = (e1 > 15) ? 4'd15 : 4'(e1);
         e2b = 4'(e2);

         for (int ln = 0; ln < 4; ln++) begin
            ra[ln] = pre[ln] ? FWD[ln] : REVIN[ln];
            rb[ln] = pre[ln] ? tb_bit  : REVIN[ln];
         end
         if (idx == 1070) begin
            ra = 4'h0;
            rb = 4'h0;
         end

         push_all(lk, al, {8'd0, e2a, e1a, 8'd0}, {4'd0, e2b, e1b, 4'd0}, ra, rb);
         tick();
      end

      RESET   = 1'b0;
      ERR_CLR = 1'b0;
      repeat (3) tick();

      n_checks = n_checks + 1;
      if (sb_q.size() != 0) begin
         n_fail = n_fail + 1;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
